// File: rtl/alt_mge_pll_rst_pkg.sv
// Shared types for the ATX PLL reset sequencer: FSM state encoding and status widths.
package alt_mge_pll_rst_pkg;

    typedef enum logic [2:0] {
        S_PWRDN     = 3'd0,
        S_CAL_WAIT  = 3'd1,
        S_LOCK_WAIT = 3'd2,
        S_MCGB_RST  = 3'd3,
        S_READY     = 3'd4
    } seq_state_t;

    localparam int LOCK_LOSS_CNT_W = 8;

endpackage

// File: rtl/alt_mge_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; resets to 0.
module alt_mge_sync_bit #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= '0;
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/alt_mge_atx_pll_rst_seq.sv
// ATX PLL power-up/reset sequencer: powerdown, calibration wait, lock qualification, MCGB reset, retry.
// Defining ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN adds the saturating lock_loss_cnt output.
//
// state       | meaning
// S_PWRDN     | pll_powerdown held for PWRDN_CYCLES; timeout counter cleared
// S_CAL_WAIT  | PLL powered, waiting for calibration to finish
// S_LOCK_WAIT | waiting for LOCK_STABLE_CYCLES consecutive lock samples
// S_MCGB_RST  | lock qualified, master CGB held in reset for MCGB_RST_CYCLES
// S_READY     | PLL usable downstream; loss of lock drops back to S_LOCK_WAIT
module alt_mge_atx_pll_rst_seq
    import alt_mge_pll_rst_pkg::*;
#(
    parameter int PWRDN_CYCLES        = 100,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int MCGB_RST_CYCLES     = 16,
    parameter int SYNC_STAGES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_reset,
    input  logic       pll_locked,
    input  logic       pll_cal_busy,
    output logic       pll_powerdown,
    output logic       mcgb_rst,
    output logic       pll_ready,
    output logic       timeout_err,
`ifdef ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN
    output logic [2:0] seq_state,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
`else
    output logic [2:0] seq_state
`endif
);

    localparam int PWR_W  = $clog2(PWRDN_CYCLES + 1);
    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int MCGB_W = $clog2(MCGB_RST_CYCLES + 1);

    localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWRDN_CYCLES - 1);
    localparam logic [PWR_W-1:0]  PWR_MAX   = PWR_W'(PWRDN_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [MCGB_W-1:0] MCGB_LAST = MCGB_W'(MCGB_RST_CYCLES - 1);
    localparam logic [MCGB_W-1:0] MCGB_MAX  = MCGB_W'(MCGB_RST_CYCLES);

    seq_state_t        state;
    seq_state_t        nxt;
    logic              lock_s;
    logic              cal_s;
    logic              to_hit;
    logic              lock_lost;
    logic [PWR_W-1:0]  pwr_cnt;
    logic [STAB_W-1:0] stab_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [MCGB_W-1:0] mcgb_cnt;

    alt_mge_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    alt_mge_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cal (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_cal_busy),
        .q     (cal_s)
    );

    // Priority: req_reset over timeout over lock qualification.
    always_comb begin
        nxt    = state;
        to_hit = ((state == S_CAL_WAIT) || (state == S_LOCK_WAIT)) && (to_cnt == TO_LAST);
        case (state)
            S_PWRDN:     if (pwr_cnt == PWR_LAST) nxt = S_CAL_WAIT;
            S_CAL_WAIT:  if (to_hit) nxt = S_PWRDN;
                         else if (!cal_s) nxt = S_LOCK_WAIT;
            S_LOCK_WAIT: if (to_hit) nxt = S_PWRDN;
                         else if (lock_s && (stab_cnt == STAB_LAST)) nxt = S_MCGB_RST;
            S_MCGB_RST:  if (!lock_s) nxt = S_LOCK_WAIT;
                         else if (mcgb_cnt == MCGB_LAST) nxt = S_READY;
            S_READY:     if (!lock_s) nxt = S_LOCK_WAIT;
            default:     nxt = S_PWRDN;
        endcase
        if (req_reset) nxt = S_PWRDN;
    end

    assign lock_lost = (state == S_READY) && (nxt == S_LOCK_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PWRDN;
            pll_powerdown <= 1'b1;
            mcgb_rst      <= 1'b1;
            pll_ready     <= 1'b0;
            timeout_err   <= 1'b0;
            pwr_cnt       <= '0;
            stab_cnt      <= '0;
            to_cnt        <= '0;
            mcgb_cnt      <= '0;
        end else begin
            state         <= nxt;
            pll_powerdown <= (nxt == S_PWRDN);
            mcgb_rst      <= (nxt != S_READY);
            pll_ready     <= (nxt == S_READY);

            if (req_reset)   timeout_err <= 1'b0;
            else if (to_hit) timeout_err <= 1'b1;

            if ((state == S_PWRDN) && (nxt == S_PWRDN) && !req_reset) begin
                if (pwr_cnt != PWR_MAX) pwr_cnt <= pwr_cnt + 1'b1;
            end else begin
                pwr_cnt <= '0;
            end

            if ((state == S_LOCK_WAIT) && (nxt == S_LOCK_WAIT) && lock_s) begin
                if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end

            // Held through S_MCGB_RST so a lock drop there keeps the original deadline.
            if ((nxt == S_PWRDN) || lock_lost) begin
                to_cnt <= '0;
            end else if (((state == S_CAL_WAIT) || (state == S_LOCK_WAIT)) && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if ((state == S_MCGB_RST) && (nxt == S_MCGB_RST)) begin
                if (mcgb_cnt != MCGB_MAX) mcgb_cnt <= mcgb_cnt + 1'b1;
            end else begin
                mcgb_cnt <= '0;
            end
        end
    end

    assign seq_state = state;

`ifdef ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             lock_loss_cnt <= '0;
        else if (req_reset)                     lock_loss_cnt <= '0;
        else if (lock_lost && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alt_mge_atx_pll_rst_seq.sv
// Self-checking bench for alt_mge_atx_pll_rst_seq: per-cycle reference model plus directed scenarios.
module tb_alt_mge_atx_pll_rst_seq;

    localparam int PD   = 8;
    localparam int STAB = 4;
    localparam int MC   = 3;
    localparam int TO   = 50;
    localparam int SS   = 2;

    localparam int PH_PD    = 0;
    localparam int PH_CAL   = 1;
    localparam int PH_LOCK  = 2;
    localparam int PH_MCGB  = 3;
    localparam int PH_READY = 4;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       req_reset    = 1'b0;
    logic       pll_locked   = 1'b0;
    logic       pll_cal_busy = 1'b1;
    logic       pll_powerdown;
    logic       mcgb_rst;
    logic       pll_ready;
    logic       timeout_err;
    logic [2:0] seq_state;
`ifdef ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alt_mge_atx_pll_rst_seq #(
        .PWRDN_CYCLES        (PD),
        .LOCK_STABLE_CYCLES  (STAB),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MCGB_RST_CYCLES     (MC),
        .SYNC_STAGES         (SS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_reset     (req_reset),
        .pll_locked    (pll_locked),
        .pll_cal_busy  (pll_cal_busy),
        .pll_powerdown (pll_powerdown),
        .mcgb_rst      (mcgb_rst),
        .pll_ready     (pll_ready),
        .timeout_err   (timeout_err),
`ifdef ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
`else
        .seq_state     (seq_state)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus remaining-cycle budgets, synchronizer as a two-deep sample history.
    int m_ph        = PH_PD;
    int m_pd_left   = PD;
    int m_wait_left = TO;
    int m_run       = 0;
    int m_mc_left   = MC;
    int m_loss      = 0;
    bit m_err       = 1'b0;
    bit l1 = 1'b0, l2 = 1'b0, c1 = 1'b0, c2 = 1'b0;
    bit m_ls, m_cs;

    task automatic m_enter_pd();
        m_ph        = PH_PD;
        m_pd_left   = PD;
        m_wait_left = TO;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_enter_pd();
            m_run = 0; m_mc_left = MC; m_loss = 0; m_err = 1'b0;
            l1 = 1'b0; l2 = 1'b0; c1 = 1'b0; c2 = 1'b0;
        end else begin
            m_ls = l2; m_cs = c2;
            l2 = l1; l1 = pll_locked;
            c2 = c1; c1 = pll_cal_busy;
            if (req_reset) begin
                m_enter_pd();
                m_err  = 1'b0;
                m_loss = 0;
            end else begin
                case (m_ph)
                    PH_PD: begin
                        m_pd_left--;
                        if (m_pd_left == 0) m_ph = PH_CAL;
                    end
                    PH_CAL: begin
                        m_wait_left--;
                        if (m_wait_left == 0) begin m_err = 1'b1; m_enter_pd(); end
                        else if (!m_cs) begin m_ph = PH_LOCK; m_run = 0; end
                    end
                    PH_LOCK: begin
                        m_wait_left--;
                        if (m_wait_left == 0) begin m_err = 1'b1; m_enter_pd(); end
                        else begin
                            m_run = m_ls ? m_run + 1 : 0;
                            if (m_run == STAB) begin m_ph = PH_MCGB; m_mc_left = MC; end
                        end
                    end
                    PH_MCGB: begin
                        if (!m_ls) begin m_ph = PH_LOCK; m_run = 0; end
                        else begin
                            m_mc_left--;
                            if (m_mc_left == 0) m_ph = PH_READY;
                        end
                    end
                    default: begin
                        if (!m_ls) begin
                            m_ph = PH_LOCK; m_run = 0; m_wait_left = TO;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("pll_powerdown", pll_powerdown, int'(m_ph == PH_PD));
        check("mcgb_rst",      mcgb_rst,      int'(m_ph != PH_READY));
        check("pll_ready",     pll_ready,     int'(m_ph == PH_READY));
        check("timeout_err",   timeout_err,   int'(m_err));
        check("seq_state",     seq_state,     m_ph);
`ifdef ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    end

    task automatic check_pd_width(input string name);
        int n = 0;
        while (pll_powerdown && n < 100) begin n++; @(negedge clk); end
        check(name, n, PD);
    endtask

    task automatic wait_state(input int s, input string name);
        int n = 0;
        while (int'(seq_state) != s && n < 200) begin @(negedge clk); n++; end
        check(name, seq_state, s);
    endtask

    task automatic req_pulse();
        @(negedge clk);
        req_reset = 1'b1;
        @(negedge clk);
        req_reset = 1'b0;
    endtask

    initial begin
        int n;
        bit pd_seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pd", pll_powerdown, 1);
        check("rst_mcgb", mcgb_rst, 1);
        check("rst_ready", pll_ready, 0);
        check("rst_err", timeout_err, 0);
        check("rst_state", seq_state, PH_PD);

        // Nominal bring-up
        rst_n = 1'b1;
        check_pd_width("pd_width_bringup");
        repeat (2) @(negedge clk);
        pll_cal_busy = 1'b0;
        pll_locked   = 1'b1;
        wait_state(PH_MCGB, "reach_mcgb_nominal");
        n = 0;
        while (int'(seq_state) == PH_MCGB && n < 20) begin n++; @(negedge clk); end
        check("mcgb_dwell", n, MC);
        check("nominal_ready", pll_ready, 1);
        check("nominal_mcgb_low", mcgb_rst, 0);
        check("nominal_err", timeout_err, 0);

        // req_reset pulse from READY, then lock glitch during qualification
        @(negedge clk);
        req_reset  = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        req_reset = 1'b0;
        check_pd_width("pd_width_req_ready");
        check("req_clears_err", timeout_err, 0);
        wait_state(PH_LOCK, "reach_lock_wait");
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        n = 0;
        repeat (3) begin @(negedge clk); n++; end
        pll_locked = 1'b0;
        @(negedge clk); n++;
        pll_locked = 1'b1;
        while (int'(seq_state) != PH_MCGB && n < 40) begin @(negedge clk); n++; end
        check("glitch_qual_latency", n, 10);
        wait_state(PH_READY, "ready_after_glitch");

        // Loss of lock in READY
        @(negedge clk);
        pll_locked = 1'b0;
        n = 0;
        while (pll_ready && n < 20) begin @(negedge clk); n++; end
        check("ready_fall_latency", n, 3);
        check("loss_state", seq_state, PH_LOCK);
        check("loss_mcgb", mcgb_rst, 1);
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        pd_seen = 1'b0;
        n = 0;
        while (!pll_ready && n < 60) begin
            if (pll_powerdown) pd_seen = 1'b1;
            @(negedge clk); n++;
        end
        check("loss_no_powerdown", pd_seen, 0);
        check("loss_requalified", pll_ready, 1);
`ifdef ALT_MGE_PLL_RST_SEQ_LOCK_LOSS_CNT_EN
        check("lock_loss_cnt_one", lock_loss_cnt, 1);
`endif

        // Lock timeout with full retry
        @(negedge clk);
        req_reset  = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        req_reset = 1'b0;
        check_pd_width("pd_width_pre_timeout");
        n = 0;
        while ((int'(seq_state) == PH_CAL || int'(seq_state) == PH_LOCK) && n < 200) begin
            n++; @(negedge clk);
        end
        check("timeout_window", n, TO);
        check("timeout_err_set", timeout_err, 1);
        check_pd_width("pd_width_after_timeout");
        pll_locked = 1'b1;
        wait_state(PH_READY, "ready_after_timeout");
        check("timeout_err_sticky", timeout_err, 1);

        // req_reset on the same edge as a timeout
        pll_locked = 1'b0;
        req_pulse();
        check_pd_width("pd_width_pre_collide");
        check("collide_err_cleared", timeout_err, 0);
        check("collide_in_cal", seq_state, PH_CAL);
        repeat (TO - 1) @(negedge clk);
        req_reset = 1'b1;
        @(negedge clk);
        req_reset = 1'b0;
        check("collide_err", timeout_err, 0);
        check_pd_width("pd_width_collide");

        // Async reset mid S_MCGB_RST
        pll_locked = 1'b1;
        wait_state(PH_MCGB, "reach_mcgb_async");
        #2 rst_n = 1'b0;
        #1;
        check("async_pd", pll_powerdown, 1);
        check("async_mcgb", mcgb_rst, 1);
        check("async_ready", pll_ready, 0);
        check("async_state", seq_state, PH_PD);
        check("async_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state(PH_READY, "ready_after_async");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
